// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch sequencer.
//   NOP_INSTR     : instruction presented on the output while nothing has been fetched
//   fetch_entry_t : fetch-queue payload, the instruction tagged with its PC
//   pc_align()    : clears the byte-offset bits of a PC
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] pc_align(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched instructions toward decode.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push, wdata : enqueue one entry
//   pop         : dequeue the head entry (ignored when empty)
//   flush       : drop every entry; wins over a same-cycle push
//   head        : oldest entry, read straight from the storage registers
//   head_valid  : registered "not empty"
//   count       : number of occupied entries
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         T       = fetch_entry_t,
  parameter T            RST_VAL = T'('0)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  T                       wdata,
  input  logic                   pop,
  input  logic                   flush,
  output T                       head,
  output logic                   head_valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  T              mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          valid_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && (cnt_q != CW'(0));

  // Occupancy after this cycle's push/pop.
  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage and pointers; at full, a push+pop writes the slot being vacated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= RST_VAL;
      end
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      cnt_q   <= cnt_d;
      valid_q <= (cnt_d != CW'(0));
    end
  end

  assign head       = mem[rd_ptr];
  assign head_valid = valid_q;
  assign count      = cnt_q;

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(do_push && !do_pop && (cnt_q == CW'(DEPTH))))
    else $error("fetch_fifo: push into a full queue");

  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && (cnt_q == CW'(0))))
    else $error("fetch_fifo: pop from an empty queue");

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer in front of a 1-cycle-latency i-cache.
// Owns the PC, issues one word read per cycle while queue credit allows,
// tags each response with its PC and queues it toward decode.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   fetch_en                    : permit new issues
//   redirect_valid, redirect_pc : flush and restart fetch at redirect_pc
//   ic_en, ic_addr              : i-cache read request (ic_en is combinational)
//   ic_rdata, ic_rvalid         : i-cache response, one cycle after ic_en
//   out_valid/out_ready         : handshake toward decode
//   out_instr, out_pc           : head instruction and its PC
//   fq_count                    : fetch-queue occupancy
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH    = 4,
  parameter int unsigned DEPTH_WORDS = 512
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fetch_en,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  output logic                      ic_en,
  output logic [31:0]               ic_addr,
  input  logic [31:0]               ic_rdata,
  input  logic                      ic_rvalid,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_instr,
  output logic [31:0]               out_pc,
  output logic [$clog2(FQ_DEPTH):0] fq_count
);

  localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;
  localparam int unsigned SW = CW + 1;
  localparam fetch_entry_t ENTRY_RST = '{pc: 32'h0, instr: NOP_INSTR};

  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  logic [31:0]  inflight_pc_q;
  logic [31:0]  inflight_pc_d;
  logic         inflight_q;
  logic         inflight_d;
  logic         kill_q;
  logic         kill_d;
  logic         issue;
  logic         push;
  logic         pop;
  logic [SW-1:0] credit_used;
  logic [SW-1:0] credit_lim;
  fetch_entry_t push_entry;
  fetch_entry_t head;

  assign pop = out_valid && out_ready;

  // Credit: queued + in-flight - popping must stay below FQ_DEPTH; rearranged
  // to avoid a negative intermediate. rst_n gates ic_en low during reset.
  always_comb begin
    credit_used = SW'(fq_count) + SW'(inflight_q);
    credit_lim  = SW'(FQ_DEPTH) + SW'(pop);
    issue       = rst_n && fetch_en && !redirect_valid && (credit_used < credit_lim);
  end

  assign ic_en   = issue;
  assign ic_addr = pc_q;

  // Next-state for PC, in-flight tracking and the stale-response kill flag.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    kill_d        = kill_q;
    if (issue) begin
      pc_d          = pc_q + 32'd4;
      inflight_pc_d = pc_q;
    end
    if (redirect_valid) begin
      pc_d   = pc_align(redirect_pc);
      kill_d = inflight_q;
    end else if (kill_q) begin
      kill_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
      kill_q        <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      kill_q        <= kill_d;
    end
  end

  // A response is queued only if it belongs to a live read; a same-cycle
  // redirect discards it through the queue flush.
  assign push       = ic_rvalid && inflight_q && !kill_q;
  assign push_entry = '{pc: inflight_pc_q, instr: ic_rdata};

  fetch_fifo #(
    .DEPTH   (FQ_DEPTH),
    .T       (fetch_entry_t),
    .RST_VAL (ENTRY_RST)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .wdata      (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .head       (head),
    .head_valid (out_valid),
    .count      (fq_count)
  );

  assign out_instr = head.instr;
  assign out_pc    = head.pc;

  a_rvalid_inflight : assert property (@(posedge clk) disable iff (!rst_n)
    ic_rvalid |-> inflight_q)
    else $error("fetch_ctrl: i-cache response with no read in flight");

  a_addr_range : assert property (@(posedge clk) disable iff (!rst_n)
    ic_en |-> ({2'b00, ic_addr[31:2]} < DEPTH_WORDS))
    else $warning("fetch_ctrl: i-cache address 0x%08h beyond cache depth", ic_addr);

endmodule
